// File: rtl/gan_sequencer.sv
// gan_sequencer: runs one latent-vector job at a time through an external GAN
// datapath. The FSM latches the job operands onto the datapath inputs, waits
// LATENCY cycles for the datapath to settle, captures the discriminator word
// and the nine pixel words, then holds the result until the consumer takes it.

// One captured result word; it reloads only on the capture strobe.
module gan_seq_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Hold the last captured word; reset clears it.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (cap) q <= d;
  end
endmodule

module gan_sequencer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_choice,
  input  logic [WIDTH-1:0]   in_a1,
  input  logic [WIDTH-1:0]   in_a2,
  output logic               dp_choice,
  output logic [WIDTH-1:0]   dp_in_1,
  output logic [WIDTH-1:0]   dp_in_2,
  input  logic [WIDTH-1:0]   dp_disc,
  input  logic [9*WIDTH-1:0] dp_pixels,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_disc,
  output logic [9*WIDTH-1:0] out_pixels,
  output logic               out_choice,
  output logic               busy,
  output logic [15:0]        job_count
);
  // Lanes 0..8 carry the pixel words, lane 9 the discriminator word.
  localparam int NUM_LANES = 10;
  localparam logic [7:0] LAT = 8'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_t;

  state_t                            state;
  logic [7:0]                        cnt;
  logic                              cap;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // Capture on the last WAIT edge, the same edge that moves the FSM to RESULT.
  assign cap      = (state == WAIT) && (cnt == 8'd1);

  assign lane_d     = {dp_disc, dp_pixels};
  assign out_pixels = lane_q[8:0];
  assign out_disc   = lane_q[9];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gan_seq_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .cap (cap),
      .d   (lane_d[g]),
      .q   (lane_q[g])
    );
  end

  // Job FSM: accept in IDLE, count down in WAIT, hold result in RESULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      dp_in_1    <= '0;
      dp_in_2    <= '0;
      dp_choice  <= 1'b0;
      out_choice <= 1'b0;
      out_valid  <= 1'b0;
      job_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dp_in_1   <= in_a1;
          dp_in_2   <= in_a2;
          dp_choice <= in_choice;
          cnt       <= LAT;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            out_choice <= dp_choice;
            out_valid  <= 1'b1;
            state      <= RESULT;
          end
        end
        RESULT: if (out_ready) begin
          out_valid <= 1'b0;
          job_count <= job_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gan_sequencer.sv
// Directed bench for gan_sequencer: u_a runs with LATENCY=4, u_b with LATENCY=1.
module tb_gan_sequencer;
  localparam int W = 32;

  logic           clk = 1'b0;
  int             tests = 0;
  int             fails = 0;
  logic [15:0]    exp_jobs = 16'd0;

  // instance A (LATENCY=4)
  logic           rst, in_valid, in_choice, out_ready;
  logic [W-1:0]   in_a1, in_a2, dp_disc;
  logic [9*W-1:0] dp_pixels;
  logic           in_ready, dp_choice, out_valid, out_choice, busy;
  logic [W-1:0]   dp_in_1, dp_in_2, out_disc;
  logic [9*W-1:0] out_pixels;
  logic [15:0]    job_count;

  // instance B (LATENCY=1)
  logic           rst_b, in_valid_b, in_choice_b, out_ready_b;
  logic [W-1:0]   in_a1_b, in_a2_b, dp_disc_b;
  logic [9*W-1:0] dp_pixels_b;
  logic           in_ready_b, dp_choice_b, out_valid_b, out_choice_b, busy_b;
  logic [W-1:0]   dp_in_1_b, dp_in_2_b, out_disc_b;
  logic [9*W-1:0] out_pixels_b;
  logic [15:0]    job_count_b;

  always #5 clk = ~clk;

  gan_sequencer #(.WIDTH(W), .LATENCY(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_choice(in_choice), .in_a1(in_a1), .in_a2(in_a2),
    .dp_choice(dp_choice), .dp_in_1(dp_in_1), .dp_in_2(dp_in_2),
    .dp_disc(dp_disc), .dp_pixels(dp_pixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_disc(out_disc),
    .out_pixels(out_pixels), .out_choice(out_choice), .busy(busy),
    .job_count(job_count));

  gan_sequencer #(.WIDTH(W), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_choice(in_choice_b), .in_a1(in_a1_b), .in_a2(in_a2_b),
    .dp_choice(dp_choice_b), .dp_in_1(dp_in_1_b), .dp_in_2(dp_in_2_b),
    .dp_disc(dp_disc_b), .dp_pixels(dp_pixels_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_disc(out_disc_b),
    .out_pixels(out_pixels_b), .out_choice(out_choice_b), .busy(busy_b),
    .job_count(job_count_b));

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_pixels(input logic [W-1:0] base);
    for (int i = 0; i < 9; i++) dp_pixels[i*W +: W] = base + W'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1;
    in_valid = 0; in_choice = 0; in_a1 = '0; in_a2 = '0; out_ready = 0;
    dp_disc = 32'hDEAD_0001; set_pixels(32'h0000_1000);
    in_valid_b = 0; in_choice_b = 0; in_a1_b = '0; in_a2_b = '0; out_ready_b = 1;
    dp_disc_b = 32'hB0B0_0001; dp_pixels_b = {9{32'h5555_AAAA}};
    tick(); tick();
    rst = 1'b0; rst_b = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (job_count !== 16'd0) begin fails++; $display("FAIL reset_job_count got %h want 0", job_count); end
    tests++; if ({dp_in_1, dp_in_2, dp_choice} !== '0) begin fails++; $display("FAIL reset_dp got %h %h %b want 0", dp_in_1, dp_in_2, dp_choice); end
    tests++; if ({out_disc, out_pixels, out_choice} !== '0) begin fails++; $display("FAIL reset_out got %h %b want 0", out_disc, out_choice); end
  endtask

  task automatic test_single_job();
    logic [9*W-1:0] pix;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a1 = 32'h0001_0000; in_a2 = 32'hFFFF_0000; in_choice = 1'b1;
    dp_disc = 32'h0000_1234; set_pixels(32'h0000_00A0); pix = dp_pixels;
    tick();  // accepting edge
    in_valid = 1'b0;
    tests++; if (dp_choice !== 1'b1) begin fails++; $display("FAIL single_dp_choice got %b want 1", dp_choice); end
    tests++; if (dp_in_1 !== 32'h0001_0000 || dp_in_2 !== 32'hFFFF_0000) begin fails++; $display("FAIL single_dp_in got %h %h want 00010000 ffff0000", dp_in_1, dp_in_2); end
    tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_busy got ready=%b busy=%b want 0 1", in_ready, busy); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid cycle %0d got %b want 0", c, out_valid); end
    end
    tick();  // 4 cycles after accept
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid_at_lat got %b want 1", out_valid); end
    tests++; if (out_disc !== 32'h0000_1234) begin fails++; $display("FAIL single_out_disc got %h want 00001234", out_disc); end
    tests++; if (out_pixels !== pix) begin fails++; $display("FAIL single_out_pixels got %h want %h", out_pixels, pix); end
    tests++; if (out_choice !== 1'b1) begin fails++; $display("FAIL single_out_choice got %b want 1", out_choice); end
    dp_disc = 32'h0000_9999;
    tick();  // handshake
    exp_jobs++;
    tests++; if (job_count !== exp_jobs) begin fails++; $display("FAIL single_job_count got %h want %h", job_count, exp_jobs); end
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL single_back_idle got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    tests++; if (out_disc !== 32'h0000_1234) begin fails++; $display("FAIL single_out_held got %h want 00001234", out_disc); end
  endtask

  task automatic test_backpressure();
    logic [9*W-1:0] pix;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a1 = 32'd5; in_a2 = 32'd6; in_choice = 1'b0;
    set_pixels(32'h0000_0B00); pix = dp_pixels;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", out_valid); end
    for (int c = 0; c < 10; c++) begin
      dp_pixels = ~dp_pixels;
      tick();
      tests++; if (out_pixels !== pix || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold cycle %0d got valid=%b ready=%b pix=%h want 1 0 %h", c, out_valid, in_ready, out_pixels, pix);
      end
    end
    tests++; if (job_count !== exp_jobs) begin fails++; $display("FAIL bp_count_stalled got %h want %h", job_count, exp_jobs); end
    out_ready = 1'b1;
    tick();
    exp_jobs++;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    tick(); tick();
    tests++; if (job_count !== exp_jobs) begin fails++; $display("FAIL bp_count_once got %h want %h", job_count, exp_jobs); end
  endtask

  task automatic test_ignored_request();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a1 = 32'h0000_0111; in_a2 = 32'h0; in_choice = 1'b1;
    tick();  // accept first job
    in_a1 = 32'h0000_0222;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (dp_in_1 !== 32'h0000_0111) begin fails++; $display("FAIL ign_dp_in_1 cycle %0d got %h want 00000111", c, dp_in_1); end
    end
    tick();  // capture
    tick();  // handshake, back to IDLE
    exp_jobs++;
    tests++; if (dp_in_1 !== 32'h0000_0111 || in_ready !== 1'b1) begin fails++; $display("FAIL ign_idle got dp=%h ready=%b want 00000111 1", dp_in_1, in_ready); end
    tick();  // second job accepted here
    in_valid = 1'b0;
    tests++; if (dp_in_1 !== 32'h0000_0222) begin fails++; $display("FAIL ign_second_accept got %h want 00000222", dp_in_1); end
    repeat (5) tick();
    exp_jobs++;
    tests++; if (job_count !== exp_jobs) begin fails++; $display("FAIL ign_job_count got %h want %h", job_count, exp_jobs); end
  endtask

  task automatic test_choice_switch();
    out_ready = 1'b1;
    in_valid = 1'b1; in_choice = 1'b0; in_a1 = 32'hA; in_a2 = 32'hB;
    tick();  // accept A
    in_choice = 1'b1;  // B waits with in_valid held
    tests++; if (dp_choice !== 1'b0) begin fails++; $display("FAIL choice_a_dp got %b want 0", dp_choice); end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (dp_choice !== 1'b0) begin fails++; $display("FAIL choice_a_hold cycle %0d got %b want 0", c, dp_choice); end
    end
    tick();
    tests++; if (out_valid !== 1'b1 || out_choice !== 1'b0) begin fails++; $display("FAIL choice_a_out got valid=%b choice=%b want 1 0", out_valid, out_choice); end
    tick();  // handshake A
    exp_jobs++;
    tests++; if (dp_choice !== 1'b0) begin fails++; $display("FAIL choice_idle_dp got %b want 0", dp_choice); end
    tick();  // accept B
    in_valid = 1'b0;
    tests++; if (dp_choice !== 1'b1) begin fails++; $display("FAIL choice_b_dp got %b want 1", dp_choice); end
    repeat (4) tick();
    tests++; if (out_valid !== 1'b1 || out_choice !== 1'b1) begin fails++; $display("FAIL choice_b_out got valid=%b choice=%b want 1 1", out_valid, out_choice); end
    tick();
    exp_jobs++;
    tests++; if (job_count !== exp_jobs) begin fails++; $display("FAIL choice_job_count got %h want %h", job_count, exp_jobs); end
  endtask

  task automatic test_reset_mid_wait();
    out_ready = 1'b1;
    in_valid = 1'b1; in_choice = 1'b1; in_a1 = 32'h77; in_a2 = 32'h88;
    tick();  // accept
    in_valid = 1'b0;
    tick();  // now in second WAIT cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_jobs = 16'd0;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got ready=%b busy=%b valid=%b want 1 0 0", in_ready, busy, out_valid); end
    tests++; if ({dp_in_1, dp_in_2, dp_choice} !== '0 || {out_disc, out_pixels, out_choice} !== '0) begin fails++; $display("FAIL rstmid_regs got dp=%h out=%h want 0", dp_in_1, out_disc); end
    tests++; if (job_count !== 16'd0) begin fails++; $display("FAIL rstmid_job_count got %h want 0", job_count); end
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_valid cycle %0d got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_wrap_lat1();
    force u_b.job_count = 16'hFFFF;
    #1;
    release u_b.job_count;
    #1;
    tests++; if (job_count_b !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got %h want ffff", job_count_b); end
    tick();
    in_valid_b = 1'b1; in_choice_b = 1'b1; in_a1_b = 32'h1; in_a2_b = 32'h2;
    tick();  // accept
    in_valid_b = 1'b0;
    tests++; if (out_valid_b !== 1'b0 || busy_b !== 1'b1) begin fails++; $display("FAIL lat1_accept got valid=%b busy=%b want 0 1", out_valid_b, busy_b); end
    tick();  // one cycle after accept
    tests++; if (out_valid_b !== 1'b1) begin fails++; $display("FAIL lat1_valid got %b want 1", out_valid_b); end
    tests++; if (out_disc_b !== 32'hB0B0_0001 || out_choice_b !== 1'b1) begin fails++; $display("FAIL lat1_out got %h %b want b0b00001 1", out_disc_b, out_choice_b); end
    tick();  // handshake wraps the counter
    tests++; if (job_count_b !== 16'h0000) begin fails++; $display("FAIL wrap_job_count got %h want 0000", job_count_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_job();
    test_backpressure();
    test_ignored_request();
    test_choice_switch();
    test_reset_mid_wait();
    test_wrap_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
